// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-master BRAM arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_state_t;

  typedef enum logic {
    MST0 = 1'b0,
    MST1 = 1'b1
  } mst_idx_t;

endpackage

// File: rtl/mem_arb_policy.sv
// Winner selection for the BRAM arbiter; MEM_ARBITER_RR_EN selects round-robin,
// otherwise m0 has fixed priority and no pointer register exists.
module mem_arb_policy
  import mem_arb_pkg::*;
(
`ifdef MEM_ARBITER_RR_EN
  input  logic CLOCK_50,
  input  logic rstn,
`endif
  input  logic req0,
  input  logic req1,
  input  logic hold0,
  input  logic hold1,
  output logic gnt0,
  output logic gnt1
);

`ifdef MEM_ARBITER_RR_EN
  mst_idx_t last_q;

  // Pointer starts at m1 so that m0 wins the first contention after reset.
  always_ff @(posedge CLOCK_50) begin
    if (!rstn) begin
      last_q <= MST1;
    end else if (gnt0) begin
      last_q <= MST0;
    end else if (gnt1) begin
      last_q <= MST1;
    end
  end
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (hold0) begin
      gnt0 = 1'b1;
    end else if (hold1) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
`ifdef MEM_ARBITER_RR_EN
      if (last_q == MST1) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
`else
      gnt0 = 1'b1;
`endif
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port BRAM with locked bursts and
// registered read routing. Policy macro: MEM_ARBITER_RR_EN (round-robin when defined).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                CLOCK_50,
  input  logic                rstn,
  input  logic                m0_req,
  input  logic                m0_lock,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_wmask,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m1_req,
  input  logic                m1_lock,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_wmask,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [ADDR_W-1:0]   m1_addr,
  output logic                m0_gnt,
  output logic                m1_gnt,
  output logic                m0_rvalid,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                bram_write,
  output logic [DATA_W/8-1:0] bram_wmask,
  output logic [DATA_W-1:0]   bram_wdata,
  output logic [ADDR_W-1:0]   bram_addr,
  input  logic [DATA_W-1:0]   bram_rdata
);

  own_state_t state_q, state_nxt;
  logic       lock_q, lock_nxt;
  logic       req0, req1, hold0, hold1;
  logic       rd_vld_p0;
  mst_idx_t   rd_tag_p0;

  // Nothing is granted while reset is held.
  assign req0  = m0_req & rstn;
  assign req1  = m1_req & rstn;
  assign hold0 = (state_q == OWN0) & lock_q & req0;
  assign hold1 = (state_q == OWN1) & lock_q & req1;

  mem_arb_policy u_policy (
`ifdef MEM_ARBITER_RR_EN
    .CLOCK_50 (CLOCK_50),
    .rstn     (rstn),
`endif
    .req0     (req0),
    .req1     (req1),
    .hold0    (hold0),
    .hold1    (hold1),
    .gnt0     (m0_gnt),
    .gnt1     (m1_gnt)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!rstn) begin
      state_q <= IDLE;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      lock_q  <= lock_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    lock_nxt  = 1'b0;
    if (m0_gnt) begin
      state_nxt = OWN0;
      lock_nxt  = m0_lock;
    end else if (m1_gnt) begin
      state_nxt = OWN1;
      lock_nxt  = m1_lock;
    end
  end

  always_comb begin
    bram_write = 1'b0;
    bram_wmask = '0;
    bram_wdata = '0;
    bram_addr  = '0;
    if (m0_gnt) begin
      bram_write = m0_write;
      bram_wmask = m0_wmask;
      bram_wdata = m0_wdata;
      bram_addr  = m0_addr;
    end else if (m1_gnt) begin
      bram_write = m1_write;
      bram_wmask = m1_wmask;
      bram_wdata = m1_wdata;
      bram_addr  = m1_addr;
    end
  end

  // ---- stage p0: read issued, BRAM data returns in this cycle ----
  always_ff @(posedge CLOCK_50) begin
    if (!rstn) begin
      rd_vld_p0 <= 1'b0;
      rd_tag_p0 <= MST0;
    end else begin
      rd_vld_p0 <= (m0_gnt & ~m0_write) | (m1_gnt & ~m1_write);
      rd_tag_p0 <= m1_gnt ? MST1 : MST0;
    end
  end

  assign m0_rvalid = rstn & rd_vld_p0 & (rd_tag_p0 == MST0);
  assign m1_rvalid = rstn & rd_vld_p0 & (rd_tag_p0 == MST1);
  assign m0_rdata  = m0_rvalid ? bram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? bram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural BRAM model.
module tb_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          CLOCK_50 = 1'b0;
  logic          rstn;
  logic          m0_req, m0_lock, m0_write, m1_req, m1_lock, m1_write;
  logic [3:0]    m0_wmask, m1_wmask;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bram_write;
  logic [3:0]    bram_wmask;
  logic [DW-1:0] bram_wdata;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  mem_arbiter dut (
    .CLOCK_50   (CLOCK_50),
    .rstn       (rstn),
    .m0_req     (m0_req),
    .m0_lock    (m0_lock),
    .m0_write   (m0_write),
    .m0_wmask   (m0_wmask),
    .m0_wdata   (m0_wdata),
    .m0_addr    (m0_addr),
    .m1_req     (m1_req),
    .m1_lock    (m1_lock),
    .m1_write   (m1_write),
    .m1_wmask   (m1_wmask),
    .m1_wdata   (m1_wdata),
    .m1_addr    (m1_addr),
    .m0_gnt     (m0_gnt),
    .m1_gnt     (m1_gnt),
    .m0_rvalid  (m0_rvalid),
    .m1_rvalid  (m1_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_rdata   (m1_rdata),
    .bram_write (bram_write),
    .bram_wmask (bram_wmask),
    .bram_wdata (bram_wdata),
    .bram_addr  (bram_addr),
    .bram_rdata (bram_rdata)
  );

  // Read-first BRAM with byte enables, one cycle read latency.
  always @(posedge CLOCK_50) begin
    bram_rdata <= mem[bram_addr];
    if (bram_write) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_wmask[b]) mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
      end
    end
  end

  typedef struct {
    string         name;
    logic          rstn;
    logic          r0, l0, w0;
    logic [3:0]    k0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a0;
    logic          r1, l1, w1;
    logic [3:0]    k1;
    logic [DW-1:0] d1;
    logic [AW-1:0] a1;
    logic          g0, g1;
    logic          v0;
    logic [DW-1:0] q0;
    logic          v1;
    logic [DW-1:0] q1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rs,
                     input logic r0, input logic l0, input logic w0, input logic [3:0] k0,
                     input logic [DW-1:0] d0, input logic [AW-1:0] a0,
                     input logic r1, input logic l1, input logic w1, input logic [3:0] k1,
                     input logic [DW-1:0] d1, input logic [AW-1:0] a1,
                     input logic g0, input logic g1,
                     input logic v0, input logic [DW-1:0] q0,
                     input logic v1, input logic [DW-1:0] q1);
    vec_t v;
    v.name = name; v.rstn = rs;
    v.r0 = r0; v.l0 = l0; v.w0 = w0; v.k0 = k0; v.d0 = d0; v.a0 = a0;
    v.r1 = r1; v.l1 = l1; v.w1 = w1; v.k1 = k1; v.d1 = d1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.q0 = q0; v.v1 = v1; v.q1 = q1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_row(input string name, input logic rs,
                          input logic v0, input logic [DW-1:0] q0,
                          input logic v1, input logic [DW-1:0] q1);
    add(name, rs, 0,0,0,4'h0,32'h0,14'h0, 0,0,0,4'h0,32'h0,14'h0, 0,0, v0,q0, v1,q1);
  endtask

  initial begin
    logic [DW-1:0] e_wd;
    logic [AW-1:0] e_ad;
    logic [3:0]    e_wm;
    logic          e_wr;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA500_0000 | i;

    // reset, including a request that must not be granted
    idle_row("rst0", 0, 0,0, 0,0);
    add("rst_req", 0, 1,0,0,4'h0,32'h0,14'h0010, 1,0,1,4'hF,32'h1,14'h0020, 0,0, 0,0, 0,0);

    // simultaneous reads, m0 first then m1
    add("both_c0", 1, 1,0,0,4'h0,32'h0,14'h0010, 1,0,0,4'h0,32'h0,14'h0020, 1,0, 0,0, 0,0);
    add("both_c1", 1, 0,0,0,4'h0,32'h0,14'h0000, 1,0,0,4'h0,32'h0,14'h0020, 0,1, 1,32'hA5000010, 0,0);
    idle_row("both_c2", 1, 0,0, 1,32'hA5000020);
    idle_row("both_c3", 1, 0,0, 0,0);

    // masked write then read-back
    add("wr_c0", 1, 1,0,1,4'h3,32'hDEADBEEF,14'h3F80, 0,0,0,4'h0,32'h0,14'h0, 1,0, 0,0, 0,0);
    add("wr_c1", 1, 1,0,0,4'h0,32'h0,14'h3F80, 0,0,0,4'h0,32'h0,14'h0, 1,0, 0,0, 0,0);
    idle_row("wr_c2", 1, 1,32'hA500BEEF, 0,0);
    add("wr1_c0", 1, 0,0,0,4'h0,32'h0,14'h0, 1,0,1,4'hF,32'h12345678,14'h0021, 0,1, 0,0, 0,0);
    add("wr1_c1", 1, 0,0,0,4'h0,32'h0,14'h0, 1,0,0,4'h0,32'h0,14'h0021, 0,1, 0,0, 0,0);
    idle_row("wr1_c2", 1, 0,0, 1,32'h12345678);

    // m1 locked burst; m0 waits until the cycle after lock drops
    add("lk_c0", 1, 0,0,0,4'h0,32'h0,14'h0, 1,1,1,4'hF,32'h1,14'h0100, 0,1, 0,0, 0,0);
    add("lk_c1", 1, 1,0,0,4'h0,32'h0,14'h0030, 1,1,1,4'hF,32'h2,14'h0101, 0,1, 0,0, 0,0);
    add("lk_c2", 1, 1,0,0,4'h0,32'h0,14'h0030, 1,1,1,4'hF,32'h3,14'h0102, 0,1, 0,0, 0,0);
    add("lk_c3", 1, 1,0,0,4'h0,32'h0,14'h0030, 1,0,1,4'hF,32'h4,14'h0103, 0,1, 0,0, 0,0);
    add("lk_c4", 1, 1,0,0,4'h0,32'h0,14'h0030, 1,0,1,4'hF,32'h5,14'h0104, 1,0, 0,0, 0,0);
    add("lk_c5", 1, 0,0,0,4'h0,32'h0,14'h0, 1,0,1,4'hF,32'h5,14'h0104, 0,1, 1,32'hA5000030, 0,0);
    idle_row("lk_c6", 1, 0,0, 0,0);

    // alternating back-to-back reads
    add("alt_c0", 1, 1,0,0,4'h0,32'h0,14'h0040, 0,0,0,4'h0,32'h0,14'h0, 1,0, 0,0, 0,0);
    add("alt_c1", 1, 0,0,0,4'h0,32'h0,14'h0, 1,0,0,4'h0,32'h0,14'h0041, 0,1, 1,32'hA5000040, 0,0);
    add("alt_c2", 1, 1,0,0,4'h0,32'h0,14'h0042, 0,0,0,4'h0,32'h0,14'h0, 1,0, 0,0, 1,32'hA5000041);
    idle_row("alt_c3", 1, 1,32'hA5000042, 0,0);

    // reset with a read in flight; m0 first after release
    add("rf_c0", 1, 1,0,0,4'h0,32'h0,14'h0050, 0,0,0,4'h0,32'h0,14'h0, 1,0, 0,0, 0,0);
    add("rf_c1", 0, 1,0,0,4'h0,32'h0,14'h0051, 1,0,1,4'hF,32'h9,14'h0052, 0,0, 0,0, 0,0);
    add("rf_c2", 1, 1,0,0,4'h0,32'h0,14'h0051, 1,0,0,4'h0,32'h0,14'h0052, 1,0, 0,0, 0,0);
    add("rf_c3", 1, 0,0,0,4'h0,32'h0,14'h0, 1,0,0,4'h0,32'h0,14'h0052, 0,1, 1,32'hA5000051, 0,0);
    idle_row("rf_c4", 1, 0,0, 1,32'hA5000052);

    // policy-specific contention with both requests held continuously
    idle_row("pol_rst", 0, 0,0, 0,0);
`ifdef MEM_ARBITER_RR_EN
    add("rr_c0", 1, 1,0,0,4'h0,32'h0,14'h0060, 1,0,0,4'h0,32'h0,14'h0061, 1,0, 0,0, 0,0);
    add("rr_c1", 1, 1,0,0,4'h0,32'h0,14'h0060, 1,0,0,4'h0,32'h0,14'h0061, 0,1, 1,32'hA5000060, 0,0);
    add("rr_c2", 1, 1,0,0,4'h0,32'h0,14'h0060, 1,0,0,4'h0,32'h0,14'h0061, 1,0, 0,0, 1,32'hA5000061);
    add("rr_c3", 1, 1,0,0,4'h0,32'h0,14'h0060, 1,0,0,4'h0,32'h0,14'h0061, 0,1, 1,32'hA5000060, 0,0);
    idle_row("rr_c4", 1, 0,0, 1,32'hA5000061);
`else
    add("fp_c0", 1, 1,0,0,4'h0,32'h0,14'h0060, 1,0,0,4'h0,32'h0,14'h0061, 1,0, 0,0, 0,0);
    add("fp_c1", 1, 1,0,0,4'h0,32'h0,14'h0060, 1,0,0,4'h0,32'h0,14'h0061, 1,0, 1,32'hA5000060, 0,0);
    add("fp_c2", 1, 1,0,0,4'h0,32'h0,14'h0060, 1,0,0,4'h0,32'h0,14'h0061, 1,0, 1,32'hA5000060, 0,0);
    add("fp_c3", 1, 1,0,0,4'h0,32'h0,14'h0060, 1,0,0,4'h0,32'h0,14'h0061, 1,0, 1,32'hA5000060, 0,0);
    add("fp_c4", 1, 0,0,0,4'h0,32'h0,14'h0, 1,0,0,4'h0,32'h0,14'h0061, 0,1, 1,32'hA5000060, 0,0);
    idle_row("fp_c5", 1, 0,0, 1,32'hA5000061);
`endif

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge CLOCK_50);
      rstn     = vecs[n].rstn;
      m0_req   = vecs[n].r0; m0_lock = vecs[n].l0; m0_write = vecs[n].w0;
      m0_wmask = vecs[n].k0; m0_wdata = vecs[n].d0; m0_addr = vecs[n].a0;
      m1_req   = vecs[n].r1; m1_lock = vecs[n].l1; m1_write = vecs[n].w1;
      m1_wmask = vecs[n].k1; m1_wdata = vecs[n].d1; m1_addr = vecs[n].a1;
      #5;
      // BRAM port carries the expected winner's request, zero when nobody wins.
      e_wr = 1'b0; e_wm = '0; e_wd = '0; e_ad = '0;
      if (vecs[n].g0) begin
        e_wr = vecs[n].w0; e_wm = vecs[n].k0; e_wd = vecs[n].d0; e_ad = vecs[n].a0;
      end else if (vecs[n].g1) begin
        e_wr = vecs[n].w1; e_wm = vecs[n].k1; e_wd = vecs[n].d1; e_ad = vecs[n].a1;
      end
      chk({vecs[n].name, ".m0_gnt"},    {31'b0, m0_gnt},    {31'b0, vecs[n].g0});
      chk({vecs[n].name, ".m1_gnt"},    {31'b0, m1_gnt},    {31'b0, vecs[n].g1});
      chk({vecs[n].name, ".m0_rvalid"}, {31'b0, m0_rvalid}, {31'b0, vecs[n].v0});
      chk({vecs[n].name, ".m1_rvalid"}, {31'b0, m1_rvalid}, {31'b0, vecs[n].v1});
      chk({vecs[n].name, ".m0_rdata"},  m0_rdata,           vecs[n].q0);
      chk({vecs[n].name, ".m1_rdata"},  m1_rdata,           vecs[n].q1);
      chk({vecs[n].name, ".bram_write"}, {31'b0, bram_write}, {31'b0, e_wr});
      chk({vecs[n].name, ".bram_wmask"}, {28'b0, bram_wmask}, {28'b0, e_wm});
      chk({vecs[n].name, ".bram_wdata"}, bram_wdata,          e_wd);
      chk({vecs[n].name, ".bram_addr"},  {18'b0, bram_addr},  {18'b0, e_ad});
    end

    @(negedge CLOCK_50);
    chk("mem_3f80", mem[14'h3F80], 32'hA500BEEF);
    chk("mem_0104", mem[14'h0104], 32'h00000005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
